// File: rtl/seg_bcd_feeder.sv
// Binary-to-BCD feeder for the 4-digit seven-segment scanner (sequential double-dabble).
// Optional macro SEG_HEX_BYPASS_EN adds a hex_mode input that shows raw wdata unconverted.
module seg_bcd_feeder #(
  parameter int          BIN_W    = 14,
  parameter int          MAX_VAL  = 9999,
  parameter logic [15:0] ERR_WORD = 16'hEEEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [15:0] wdata,
  output logic [15:0] ledwdata,
  output logic        LEDCtrl,
  output logic        busy
`ifdef SEG_HEX_BYPASS_EN
  ,
  input  logic        hex_mode
`endif
);

  localparam int                 CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [15:0]        MAX_WORD = 16'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg, bin_next;
  logic [15:0]        bcd_reg, bcd_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pend_reg, pend_next;
  logic [15:0]        pend_data_reg, pend_data_next;
  logic [15:0]        led_word_reg, led_word_next;
  logic               led_ctrl_reg, led_ctrl_next;
`ifdef SEG_HEX_BYPASS_EN
  logic               pend_hex_reg, pend_hex_next;
`endif

  // Add-3 correction for the three low digits; the top digit only needs its
  // low three bits because its MSB is shifted out.
  logic [11:0] low_adj;
  logic [2:0]  top_adj;
  logic [15:0] bcd_shift;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign low_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign top_adj   = (bcd_reg[15:12] >= 4'd5) ? bcd_reg[14:12] + 3'd3 : bcd_reg[14:12];
  assign bcd_shift = {top_adj, low_adj, bin_reg[BIN_W-1]};

  // Start source: a live write always beats the pending buffer.
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_hex;
  logic        src_imm;
  logic        defer;
  logic        start;

  always_comb begin
    src_valid = 1'b0;
    if (state_reg == IDLE)
      src_valid = wen;
    else if (state_reg == EMIT)
      src_valid = wen | pend_reg;
    src_data = wen ? wdata : pend_data_reg;
`ifdef SEG_HEX_BYPASS_EN
    src_hex = wen ? hex_mode : pend_hex_reg;
`else
    src_hex = 1'b0;
`endif
    src_imm = src_hex | (src_data > MAX_WORD);
    // An immediate result right behind a strobe would make LEDCtrl high two
    // cycles running, so it is parked for one EMIT cycle instead.
    defer   = (state_reg == EMIT) & src_valid & src_imm & led_ctrl_reg;
    start   = src_valid & ~defer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      bin_reg       <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
      led_word_reg  <= '0;
      led_ctrl_reg  <= 1'b0;
`ifdef SEG_HEX_BYPASS_EN
      pend_hex_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      bin_reg       <= bin_next;
      bcd_reg       <= bcd_next;
      cnt_reg       <= cnt_next;
      pend_reg      <= pend_next;
      pend_data_reg <= pend_data_next;
      led_word_reg  <= led_word_next;
      led_ctrl_reg  <= led_ctrl_next;
`ifdef SEG_HEX_BYPASS_EN
      pend_hex_reg  <= pend_hex_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start)
          state_next = src_imm ? EMIT : SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == CNT_LAST)
          state_next = EMIT;
      end
      EMIT: begin
        if (defer)
          state_next = EMIT;
        else if (start)
          state_next = src_imm ? EMIT : SHIFT;
        else
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bin_next       = bin_reg;
    bcd_next       = bcd_reg;
    cnt_next       = cnt_reg;
    pend_next      = pend_reg;
    pend_data_next = pend_data_reg;
    led_word_next  = led_word_reg;
    led_ctrl_next  = 1'b0;
`ifdef SEG_HEX_BYPASS_EN
    pend_hex_next  = pend_hex_reg;
`endif

    if (start) begin
      if (src_imm) begin
        led_word_next = src_hex ? src_data : ERR_WORD;
        led_ctrl_next = 1'b1;
      end else begin
        bin_next = src_data[BIN_W-1:0];
        bcd_next = '0;
        cnt_next = '0;
      end
      // Either the pending value was consumed or a newer write superseded it.
      pend_next = 1'b0;
    end

    if (state_reg == SHIFT) begin
      bin_next = bin_reg << 1;
      bcd_next = bcd_shift;
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == CNT_LAST) begin
        led_word_next = bcd_shift;
        led_ctrl_next = 1'b1;
      end
    end

    if ((state_reg == SHIFT && wen) || defer) begin
      pend_next      = 1'b1;
      pend_data_next = src_data;
`ifdef SEG_HEX_BYPASS_EN
      pend_hex_next  = src_hex;
`endif
    end
  end

  assign ledwdata = led_word_reg;
  assign LEDCtrl  = led_ctrl_reg;
  assign busy     = (state_reg != IDLE) | pend_reg;

endmodule

// File: tb/tb_seg_bcd_feeder.sv
// Directed bench for seg_bcd_feeder: cycle checks plus a strobe scoreboard.
module tb_seg_bcd_feeder;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [15:0] wdata;
  logic [15:0] ledwdata;
  logic        LEDCtrl;
  logic        busy;
`ifdef SEG_HEX_BYPASS_EN
  logic        hex_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb[$];
  logic        prev_ctrl = 1'b0;

  seg_bcd_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .wdata    (wdata),
    .ledwdata (ledwdata),
    .LEDCtrl  (LEDCtrl),
    .busy     (busy)
`ifdef SEG_HEX_BYPASS_EN
    ,
    .hex_mode (hex_mode)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] v);
    wen   = 1'b1;
    wdata = v;
    tick();
    wen   = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Scoreboard: every strobe pops the oldest expected display word.
  always @(negedge clk) begin
    if (LEDCtrl === 1'b1) begin
      logic [15:0] exp_word;
      n_cmp++;
      assert (prev_ctrl === 1'b0) else begin
        n_err++;
        $error("FAIL strobe_back_to_back observed=1 expected=0");
      end
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL strobe_unexpected observed=%h expected=none", ledwdata);
      end
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        chk("strobe_word", ledwdata, exp_word);
        $display("strobe ledwdata=%h expected=%h", ledwdata, exp_word);
      end
    end
    prev_ctrl = LEDCtrl;
  end

  initial begin
    rst   = 1'b0;
    wen   = 1'b0;
    wdata = 16'h0000;
`ifdef SEG_HEX_BYPASS_EN
    hex_mode = 1'b0;
`endif
    #3;
    chk("reset_word", ledwdata, 16'h0000);
    chk("reset_ctrl", {15'd0, LEDCtrl}, 16'd0);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    run(2);
    rst = 1'b1;
    run(2);

    // 1234: strobe exactly 14 cycles after the sampled write
    sb.push_back(16'h1234);
    do_write(16'd1234);
    sample();
    chk("t1_busy_e0", {15'd0, busy}, 16'd1);
    for (int k = 1; k <= 13; k++) begin
      tick();
      sample();
      chk("t1_no_ctrl", {15'd0, LEDCtrl}, 16'd0);
    end
    tick();
    sample();
    chk("t1_ctrl_e14", {15'd0, LEDCtrl}, 16'd1);
    chk("t1_word_e14", ledwdata, 16'h1234);
    tick();
    sample();
    chk("t1_ctrl_e15", {15'd0, LEDCtrl}, 16'd0);
    chk("t1_busy_e15", {15'd0, busy}, 16'd0);
    chk("t1_hold", ledwdata, 16'h1234);

    // Largest value, then zero
    sb.push_back(16'h9999);
    do_write(16'd9999);
    run(16);
    chk("t2_word_9999", ledwdata, 16'h9999);
    sb.push_back(16'h0000);
    do_write(16'd0);
    run(16);
    chk("t2_word_0", ledwdata, 16'h0000);
    chk("t2_busy", {15'd0, busy}, 16'd0);

    // Out of range: immediate error word, no conversion
    sb.push_back(16'hEEEE);
    do_write(16'd10000);
    sample();
    chk("t3_ctrl_e0", {15'd0, LEDCtrl}, 16'd1);
    chk("t3_word", ledwdata, 16'hEEEE);
    tick();
    sample();
    chk("t3_busy_e1", {15'd0, busy}, 16'd0);
    sb.push_back(16'hEEEE);
    do_write(16'hFFFF);
    sample();
    chk("t3_ctrl_ffff", {15'd0, LEDCtrl}, 16'd1);
    tick();

    // Pending buffer: latest write wins, busy stays high
    sb.push_back(16'h0005);
    sb.push_back(16'h0007);
    do_write(16'd5);
    run(2);
    do_write(16'd6);
    tick();
    do_write(16'd7);
    for (int k = 6; k <= 29; k++) begin
      tick();
      sample();
      chk("t4_busy_high", {15'd0, busy}, 16'd1);
    end
    tick();
    sample();
    chk("t4_busy_end", {15'd0, busy}, 16'd0);
    chk("t4_word", ledwdata, 16'h0007);

    // Reset mid-conversion: nothing queued, so any strobe is flagged
    do_write(16'd4321);
    run(6);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_word", ledwdata, 16'h0000);
    chk("t5_ctrl", {15'd0, LEDCtrl}, 16'd0);
    chk("t5_busy", {15'd0, busy}, 16'd0);
    run(2);
    rst = 1'b1;
    run(20);
    chk("t5_word_after", ledwdata, 16'h0000);
    chk("t5_busy_after", {15'd0, busy}, 16'd0);

    // Pending out-of-range value queued behind a conversion
    sb.push_back(16'h0001);
    sb.push_back(16'hEEEE);
    do_write(16'd1);
    run(2);
    do_write(16'hFFFF);
    run(20);
    chk("t6_word", ledwdata, 16'hEEEE);
    chk("t6_busy", {15'd0, busy}, 16'd0);

`ifdef SEG_HEX_BYPASS_EN
    sb.push_back(16'hBEEF);
    hex_mode = 1'b1;
    do_write(16'hBEEF);
    hex_mode = 1'b0;
    sample();
    chk("hex_ctrl", {15'd0, LEDCtrl}, 16'd1);
    chk("hex_word", ledwdata, 16'hBEEF);
    tick();
    sb.push_back(16'hEEEE);
    do_write(16'hBEEF);
    sample();
    chk("hex_off_word", ledwdata, 16'hEEEE);
    tick();
`endif

    run(2);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
